dram_fifo_ctrl: RTL and testbench

DRAM_FIFO_CTRL -- requirements
Module: dram_fifo_ctrl

---
 rtl/dram_fifo_ctrl_if.sv | 26 ++
 rtl/dram_fifo_ctrl.sv | 93 +++++++++
 tb/tb_dram_fifo_ctrl.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/dram_fifo_ctrl_if.sv
// Handshake and RAM64M8 port bundle for dram_fifo_ctrl.
// The slave side is the controller; the master side is the user plus RAM.
interface dram_fifo_ctrl_if;
  logic       PUSH;
  logic [7:0] DIN;
  logic       FULL;
  logic       POP;
  logic [7:0] DOUT;
  logic       DOUT_VLD;
  logic [5:0] RAM_ADDR;
  logic       RAM_WE;
  logic [7:0] RAM_DI;
  logic [7:0] RAM_DO;

  modport slave (
    input  PUSH, DIN, POP, RAM_DO,
    output FULL, DOUT, DOUT_VLD,
    output RAM_ADDR, RAM_WE, RAM_DI
  );

  modport master (
    output PUSH, DIN, POP, RAM_DO,
    input  FULL, DOUT, DOUT_VLD,
    input  RAM_ADDR, RAM_WE, RAM_DI
  );
endinterface

// File: rtl/dram_fifo_ctrl.sv
// 65-word FWFT FIFO: 64x8 RAM64M8 plus an output register.
// Define DRAM_FIFO_LEVEL_EN to add the registered LEVEL output.
module dram_fifo_ctrl (
  input  logic CLK,
  input  logic RST_N,
`ifdef DRAM_FIFO_LEVEL_EN
  output logic [6:0] LEVEL,
`endif
  dram_fifo_ctrl_if.slave bus
);

  logic [5:0] wptr_q, wptr_d;
  logic [5:0] rptr_q, rptr_d;
  logic [6:0] cnt_q, cnt_d;
  logic [7:0] dout_q, dout_d;
  logic       vld_q, vld_d;
  logic       full_q, full_d;
  logic       accept;
  logic       out_free;
  logic       bypass;
  logic       ram_wr;
  logic       prefetch;

  always_comb begin
    accept   = bus.PUSH & ~full_q;
    out_free = ~vld_q | bus.POP;
    bypass   = accept & (cnt_q == 7'd0) & out_free;
    ram_wr   = accept & ~bypass;
    // a RAM write owns the single address port
    prefetch = ~ram_wr & (cnt_q != 7'd0) & out_free;

    wptr_d = wptr_q + {5'd0, ram_wr};
    rptr_d = rptr_q + {5'd0, prefetch};
    cnt_d  = cnt_q + {6'd0, ram_wr}
                   - {6'd0, prefetch};
    full_d = (cnt_d == 7'd64);

    dout_d = dout_q;
    vld_d  = vld_q & ~bus.POP;
    unique case (1'b1)
      bypass: begin
        dout_d = bus.DIN;
        vld_d  = 1'b1;
      end
      prefetch: begin
        dout_d = bus.RAM_DO;
        vld_d  = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
      dout_q <= '0;
      vld_q  <= 1'b0;
      full_q <= 1'b0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
      dout_q <= dout_d;
      vld_q  <= vld_d;
      full_q <= full_d;
    end
  end

`ifdef DRAM_FIFO_LEVEL_EN
  logic [6:0] level_q, level_d;

  always_comb begin
    level_d = cnt_d + {6'd0, vld_d};
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) level_q <= '0;
    else        level_q <= level_d;
  end

  assign LEVEL = level_q;
`endif

  assign bus.RAM_WE   = ram_wr & RST_N;
  assign bus.RAM_ADDR = ram_wr ? wptr_q : rptr_q;
  assign bus.RAM_DI   = bus.DIN;
  assign bus.FULL     = full_q;
  assign bus.DOUT     = dout_q;
  assign bus.DOUT_VLD = vld_q;

endmodule

// File: tb/tb_dram_fifo_ctrl.sv
// Randomized and directed bench for dram_fifo_ctrl.
// Reference model: a queue of all stored words plus a "presented" flag.
module tb_dram_fifo_ctrl;

  logic CLK = 1'b0;
  logic RST_N = 1'b0;
`ifdef DRAM_FIFO_LEVEL_EN
  logic [6:0] LEVEL;
`endif

  dram_fifo_ctrl_if bus ();

  dram_fifo_ctrl dut (
    .CLK   (CLK),
    .RST_N (RST_N),
`ifdef DRAM_FIFO_LEVEL_EN
    .LEVEL (LEVEL),
`endif
    .bus   (bus.slave)
  );

  always #5 CLK = ~CLK;

  // behavioural RAM64M8: synchronous write, asynchronous read
  logic [7:0] mem [64];
  always @(posedge CLK) if (bus.RAM_WE) mem[bus.RAM_ADDR] <= bus.RAM_DI;
  assign bus.RAM_DO = mem[bus.RAM_ADDR];

  int vectors = 0;
  int miscompares = 0;

  logic [7:0] q[$];
  bit         m_vld;
  logic [7:0] m_last;

  task automatic chk(string tag, logic [7:0] got, logic [7:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic chk_outputs();
    chk("dout_vld", {7'd0, bus.DOUT_VLD}, {7'd0, m_vld});
    chk("dout", bus.DOUT, m_last);
    chk("full", {7'd0, bus.FULL},
        {7'd0, (q.size() - int'(m_vld)) == 64});
`ifdef DRAM_FIFO_LEVEL_EN
    chk("level", {1'b0, LEVEL}, 8'(q.size()));
`endif
  endtask

  task automatic do_reset();
    @(negedge CLK);
    RST_N = 1'b0;
    bus.PUSH = 1'b0;
    bus.POP = 1'b0;
    bus.DIN = 8'h00;
    #1;
    q.delete();
    m_vld = 1'b0;
    m_last = 8'h00;
    chk_outputs();
    chk("ram_we_rst", {7'd0, bus.RAM_WE}, 8'h00);
    @(negedge CLK);
    RST_N = 1'b1;
  endtask

  task automatic cyc(bit p, logic [7:0] d, bit o);
    int  r;
    bit  acc, cons, byp, wr;
    @(negedge CLK);
    bus.PUSH = p;
    bus.DIN = d;
    bus.POP = o;
    #1;
    r    = q.size() - int'(m_vld);
    acc  = p && (r != 64);
    cons = o && m_vld;
    byp  = acc && (r == 0) && (!m_vld || o);
    wr   = acc && !byp;
    chk("ram_we", {7'd0, bus.RAM_WE}, {7'd0, wr});
    @(posedge CLK);
    #1;
    if (cons) void'(q.pop_front());
    if (acc) q.push_back(d);
    if (byp) begin
      m_vld = 1'b1;
      m_last = d;
    end else if (wr) begin
      m_vld = m_vld && !o;
    end else if (r > 0 && (!m_vld || o)) begin
      m_vld = 1'b1;
      m_last = q[0];
    end else if (cons) begin
      m_vld = 1'b0;
    end
    chk_outputs();
  endtask

  initial begin
    bus.PUSH = 1'b0;
    bus.POP = 1'b0;
    bus.DIN = 8'h00;

    // single push into empty FIFO goes straight to DOUT
    do_reset();
    cyc(1, 8'hA5, 0);
    chk("a5_dout", bus.DOUT, 8'hA5);
    cyc(0, 8'h00, 0);

    // fill to 65, drop a push while full, then drain
    do_reset();
    for (int i = 0; i <= 64; i++) cyc(1, 8'(i), 0);
    chk("full_after_65", {7'd0, bus.FULL}, 8'h01);
    cyc(1, 8'hFF, 0);
    chk("drop_full", {7'd0, bus.FULL}, 8'h01);
    cyc(0, 8'h00, 1);
    for (int i = 0; i < 70; i++) cyc(0, 8'h00, 1);
    chk("drained", {7'd0, bus.DOUT_VLD}, 8'h00);
    chk("last_word", bus.DOUT, 8'h40);

    // pop on empty is ignored
    cyc(0, 8'h00, 1);

    // steady push+pop over pointer wrap
    do_reset();
    for (int i = 0; i < 10; i++) cyc(1, 8'($urandom), 0);
    for (int i = 0; i < 100; i++) cyc(1, 8'($urandom), 1);
    for (int i = 0; i < 80; i++) cyc(0, 8'h00, 1);

    // reset mid-burst with 20 stored words
    do_reset();
    for (int i = 0; i < 20; i++) cyc(1, 8'($urandom), 0);
    do_reset();
    cyc(1, 8'h3C, 0);
    chk("first_after_rst", bus.DOUT, 8'h3C);
    cyc(0, 8'h00, 1);

`ifdef DRAM_FIFO_LEVEL_EN
    do_reset();
    cyc(1, 8'h01, 0); chk("lvl1", {1'b0, LEVEL}, 8'd1);
    cyc(1, 8'h02, 0); chk("lvl2", {1'b0, LEVEL}, 8'd2);
    cyc(1, 8'h03, 0); chk("lvl3", {1'b0, LEVEL}, 8'd3);
    cyc(0, 8'h00, 1); chk("lvl4", {1'b0, LEVEL}, 8'd2);
    for (int i = 0; i < 70; i++) cyc(1, 8'($urandom), 0);
    chk("lvl_full", {1'b0, LEVEL}, 8'd65);
`endif

    // random phases alternating fill-heavy and drain-heavy traffic
    do_reset();
    for (int ph = 0; ph < 8; ph++) begin
      int pp;
      int op;
      pp = ph[0] ? 30 : 85;
      op = ph[0] ? 85 : 30;
      for (int i = 0; i < 300; i++) begin
        if ($urandom_range(999) == 0) do_reset();
        cyc($urandom_range(99) < pp, 8'($urandom),
            $urandom_range(99) < op);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
